id_ex_stage: RTL and testbench

- ID/EX pipeline stage directly downstream of the 16x16 register file.
- Captures the two read operands and the decoded control fields into EX-stage registers.
- Detects load-use hazards against the instruction currently in EX, and then stalls IF/ID and injects a bubble.
- Honours a memory-stall freeze and a branch flush, and keeps a saturating count of load-use bubbles for performance monitoring.

---
 rtl/id_ex_stage.sv | 138 +++++++++++++
 tb/tb_id_ex_stage.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, memory-stall freeze,
// branch flush and a saturating count of inserted load-use bubbles.
module id_ex_stage #(
  parameter int DATA_W   = 16,
  parameter int REG_ID_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [3:0]          id_opcode,
  input  logic [REG_ID_W-1:0] id_src1,
  input  logic [REG_ID_W-1:0] id_src2,
  input  logic                id_uses_src1,
  input  logic                id_uses_src2,
  input  logic [REG_ID_W-1:0] id_dst,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  input  logic                id_mem_write,
  input  logic [DATA_W-1:0]   id_imm,
  input  logic [DATA_W-1:0]   id_pc,
  input  logic [DATA_W-1:0]   rf_data1,
  input  logic [DATA_W-1:0]   rf_data2,
  input  logic                mem_stall,
  input  logic                flush,
  output logic                stall_if_id,
  output logic                ex_valid,
  output logic [3:0]          ex_opcode,
  output logic [REG_ID_W-1:0] ex_src1,
  output logic [REG_ID_W-1:0] ex_src2,
  output logic [REG_ID_W-1:0] ex_dst,
  output logic                ex_reg_write,
  output logic                ex_mem_read,
  output logic                ex_mem_write,
  output logic [DATA_W-1:0]   ex_data1,
  output logic [DATA_W-1:0]   ex_data2,
  output logic [DATA_W-1:0]   ex_imm,
  output logic [DATA_W-1:0]   ex_pc,
  output logic [15:0]         bubble_count
);

  localparam logic [REG_ID_W-1:0] ID_ZERO   = {REG_ID_W{1'b0}};
  localparam logic [DATA_W-1:0]   DATA_ZERO = {DATA_W{1'b0}};

  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    if (value == 16'hFFFF) begin
      sat_inc = 16'hFFFF;
    end else begin
      sat_inc = value + 16'd1;
    end
  endfunction

  logic                r_ex_valid;
  logic [3:0]          r_ex_opcode;
  logic [REG_ID_W-1:0] r_ex_src1;
  logic [REG_ID_W-1:0] r_ex_src2;
  logic [REG_ID_W-1:0] r_ex_dst;
  logic                r_ex_reg_write;
  logic                r_ex_mem_read;
  logic                r_ex_mem_write;
  logic [DATA_W-1:0]   r_ex_data1;
  logic [DATA_W-1:0]   r_ex_data2;
  logic [DATA_W-1:0]   r_ex_imm;
  logic [DATA_W-1:0]   r_ex_pc;
  logic [15:0]         r_bubble_count;

  logic w_src1_hit;
  logic w_src2_hit;
  logic w_load_use;
  logic w_bubble;

  // Hazard detection against the load sitting in EX; ID 0 is an ordinary register.
  always_comb begin
    w_src1_hit = id_uses_src1 & (id_src1 == r_ex_dst);
    w_src2_hit = id_uses_src2 & (id_src2 == r_ex_dst);
    w_load_use = r_ex_valid & r_ex_mem_read & id_valid & (w_src1_hit | w_src2_hit);
    w_bubble   = flush | w_load_use | ~id_valid;
    if (rst) begin
      stall_if_id = 1'b0;
    end else begin
      stall_if_id = mem_stall | (w_load_use & ~flush);
    end
  end

  // EX-stage register: reset, freeze, deterministic bubble or load from ID.
  always_ff @(posedge clk) begin
    if (rst || (!mem_stall && w_bubble)) begin
      r_ex_valid     <= 1'b0;
      r_ex_opcode    <= 4'h0;
      r_ex_src1      <= ID_ZERO;
      r_ex_src2      <= ID_ZERO;
      r_ex_dst       <= ID_ZERO;
      r_ex_reg_write <= 1'b0;
      r_ex_mem_read  <= 1'b0;
      r_ex_mem_write <= 1'b0;
      r_ex_data1     <= DATA_ZERO;
      r_ex_data2     <= DATA_ZERO;
      r_ex_imm       <= DATA_ZERO;
      r_ex_pc        <= DATA_ZERO;
    end else if (!mem_stall) begin
      r_ex_valid     <= 1'b1;
      r_ex_opcode    <= id_opcode;
      r_ex_src1      <= id_src1;
      r_ex_src2      <= id_src2;
      r_ex_dst       <= id_dst;
      r_ex_reg_write <= id_reg_write;
      r_ex_mem_read  <= id_mem_read;
      r_ex_mem_write <= id_mem_write;
      r_ex_data1     <= rf_data1;
      r_ex_data2     <= rf_data2;
      r_ex_imm       <= id_imm;
      r_ex_pc        <= id_pc;
    end
  end

  // Load-use bubble counter; flush takes priority so a squashed hazard is not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_count <= 16'h0000;
    end else if (!mem_stall && !flush && w_load_use) begin
      r_bubble_count <= sat_inc(r_bubble_count);
    end
  end

  assign ex_valid     = r_ex_valid;
  assign ex_opcode    = r_ex_opcode;
  assign ex_src1      = r_ex_src1;
  assign ex_src2      = r_ex_src2;
  assign ex_dst       = r_ex_dst;
  assign ex_reg_write = r_ex_reg_write;
  assign ex_mem_read  = r_ex_mem_read;
  assign ex_mem_write = r_ex_mem_write;
  assign ex_data1     = r_ex_data1;
  assign ex_data2     = r_ex_data2;
  assign ex_imm       = r_ex_imm;
  assign ex_pc        = r_ex_pc;
  assign bubble_count = r_bubble_count;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [3:0]  id_opcode = 4'h0;
  logic [3:0]  id_src1 = 4'h0, id_src2 = 4'h0, id_dst = 4'h0;
  logic        id_uses_src1 = 1'b0, id_uses_src2 = 1'b0;
  logic        id_reg_write = 1'b0, id_mem_read = 1'b0, id_mem_write = 1'b0;
  logic [15:0] id_imm = 16'h0, id_pc = 16'h0, rf_data1 = 16'h0, rf_data2 = 16'h0;
  logic        mem_stall = 1'b0, flush = 1'b0;
  logic        stall_if_id, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [3:0]  ex_opcode, ex_src1, ex_src2, ex_dst;
  logic [15:0] ex_data1, ex_data2, ex_imm, ex_pc, bubble_count;

  int n_checks = 0;
  int n_pass   = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_src1(id_src1), .id_src2(id_src2), .id_uses_src1(id_uses_src1),
    .id_uses_src2(id_uses_src2), .id_dst(id_dst), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_imm(id_imm),
    .id_pc(id_pc), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .mem_stall(mem_stall), .flush(flush), .stall_if_id(stall_if_id),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_src1(ex_src1),
    .ex_src2(ex_src2), .ex_dst(ex_dst), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one decoded instruction into the ID slot.
  task automatic set_id(input logic v, input logic [3:0] op, input logic [3:0] s1,
                        input logic u1, input logic [3:0] s2, input logic u2,
                        input logic [3:0] d, input logic rw, input logic mr,
                        input logic mw, input logic [15:0] imm, input logic [15:0] pc,
                        input logic [15:0] d1, input logic [15:0] d2);
    id_valid = v; id_opcode = op; id_src1 = s1; id_uses_src1 = u1;
    id_src2 = s2; id_uses_src2 = u2; id_dst = d; id_reg_write = rw;
    id_mem_read = mr; id_mem_write = mw; id_imm = imm; id_pc = pc;
    rf_data1 = d1; rf_data2 = d2;
  endtask

  task automatic test_reset();
    logic [84:0] all_ex;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_id(1'b1, 4'($urandom), 4'($urandom), 1'b1, 4'($urandom), 1'b1, 4'($urandom),
             1'b1, 1'b1, 1'($urandom), 16'($urandom), 16'($urandom),
             16'($urandom), 16'($urandom));
      mem_stall = 1'b1;
      flush = 1'($urandom);
      #1;
      n_checks++;
      if (stall_if_id !== 1'b0) $display("FAIL reset_stall got %b want 0", stall_if_id);
      else n_pass++;
      tick();
    end
    all_ex = {ex_valid, ex_opcode, ex_src1, ex_src2, ex_dst, ex_reg_write, ex_mem_read,
              ex_mem_write, ex_data1, ex_data2, ex_imm, ex_pc};
    n_checks++;
    if (all_ex !== 85'd0) $display("FAIL reset_ex got %h want 0", all_ex);
    else n_pass++;
    n_checks++;
    if (bubble_count !== 16'h0000) $display("FAIL reset_count got %h want 0", bubble_count);
    else n_pass++;
    rst = 1'b0; mem_stall = 1'b0; flush = 1'b0;
    set_id(1'b1, 4'h1, 4'h3, 1'b1, 4'h0, 1'b0, 4'h2, 1'b1, 1'b0, 1'b0,
           16'h00FF, 16'h0010, 16'h1234, 16'h0000);
    tick();
    n_checks++;
    if ({ex_valid, ex_src1, ex_data1, ex_imm} !== {1'b1, 4'h3, 16'h1234, 16'h00FF})
      $display("FAIL reset_release got %b %h %h %h want 1 3 1234 00ff",
               ex_valid, ex_src1, ex_data1, ex_imm);
    else n_pass++;
  endtask

  task automatic test_load_use();
    set_id(1'b1, 4'h8, 4'h1, 1'b1, 4'h0, 1'b0, 4'h5, 1'b1, 1'b1, 1'b0,
           16'h0004, 16'h0020, 16'h0000, 16'h0000);
    tick();
    set_id(1'b1, 4'h2, 4'h1, 1'b1, 4'h5, 1'b1, 4'h6, 1'b1, 1'b0, 1'b0,
           16'h0000, 16'h0022, 16'h1111, 16'h2222);
    #1;
    n_checks++;
    if (stall_if_id !== 1'b1) $display("FAIL lu_stall got %b want 1", stall_if_id);
    else n_pass++;
    tick();
    n_checks++;
    if ({ex_valid, ex_mem_read, ex_src2, ex_pc, bubble_count} !==
        {1'b0, 1'b0, 4'h0, 16'h0000, 16'h0001})
      $display("FAIL lu_bubble got v=%b mr=%b s2=%h pc=%h cnt=%h want 0 0 0 0000 0001",
               ex_valid, ex_mem_read, ex_src2, ex_pc, bubble_count);
    else n_pass++;
    n_checks++;
    if (stall_if_id !== 1'b0) $display("FAIL lu_stall_one_cycle got %b want 0", stall_if_id);
    else n_pass++;
    tick();
    n_checks++;
    if ({ex_valid, ex_src2, ex_dst, ex_data2, ex_pc} !== {1'b1, 4'h5, 4'h6, 16'h2222, 16'h0022})
      $display("FAIL lu_reload got v=%b s2=%h d=%h d2=%h pc=%h want 1 5 6 2222 0022",
               ex_valid, ex_src2, ex_dst, ex_data2, ex_pc);
    else n_pass++;
  endtask

  task automatic test_no_false_hazard();
    set_id(1'b1, 4'h8, 4'h1, 1'b1, 4'h0, 1'b0, 4'h5, 1'b1, 1'b1, 1'b0,
           16'h0000, 16'h0030, 16'h0000, 16'h0000);
    tick();
    // src2 matches the load but is not read
    set_id(1'b1, 4'h2, 4'h7, 1'b1, 4'h5, 1'b0, 4'h5, 1'b1, 1'b0, 1'b0,
           16'h0000, 16'h0032, 16'h0777, 16'h0555);
    #1;
    n_checks++;
    if (stall_if_id !== 1'b0) $display("FAIL nfh_unused_stall got %b want 0", stall_if_id);
    else n_pass++;
    tick();
    n_checks++;
    if ({ex_valid, ex_pc, bubble_count} !== {1'b1, 16'h0032, 16'h0001})
      $display("FAIL nfh_unused got v=%b pc=%h cnt=%h want 1 0032 0001",
               ex_valid, ex_pc, bubble_count);
    else n_pass++;
    set_id(1'b1, 4'h3, 4'h5, 1'b1, 4'h5, 1'b1, 4'h9, 1'b1, 1'b0, 1'b0,
           16'h0000, 16'h0034, 16'h0000, 16'h0000);
    #1;
    n_checks++;
    if (stall_if_id !== 1'b0) $display("FAIL nfh_notload_stall got %b want 0", stall_if_id);
    else n_pass++;
    tick();
    n_checks++;
    if ({ex_valid, ex_pc, bubble_count} !== {1'b1, 16'h0034, 16'h0001})
      $display("FAIL nfh_notload got v=%b pc=%h cnt=%h want 1 0034 0001",
               ex_valid, ex_pc, bubble_count);
    else n_pass++;
    set_id(1'b1, 4'h8, 4'h1, 1'b1, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0,
           16'h0000, 16'h0036, 16'h0000, 16'h0000);
    tick();
    set_id(1'b1, 4'h2, 4'h0, 1'b1, 4'h4, 1'b0, 4'h4, 1'b1, 1'b0, 1'b0,
           16'h0000, 16'h0038, 16'h0000, 16'h0000);
    #1;
    n_checks++;
    if (stall_if_id !== 1'b1) $display("FAIL r0_stall got %b want 1", stall_if_id);
    else n_pass++;
    tick();
    n_checks++;
    if ({ex_valid, bubble_count} !== {1'b0, 16'h0002})
      $display("FAIL r0_bubble got v=%b cnt=%h want 0 0002", ex_valid, bubble_count);
    else n_pass++;
    tick();
  endtask

  task automatic test_mem_stall();
    set_id(1'b1, 4'h3, 4'h1, 1'b1, 4'h2, 1'b1, 4'h3, 1'b1, 1'b0, 1'b1,
           16'h0042, 16'h0100, 16'hAAAA, 16'hBBBB);
    tick();
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 4'(i + 4), 4'(i), 1'b1, 4'(i + 1), 1'b1, 4'(i + 2), 1'b1, 1'b0,
             1'b0, 16'(i), 16'(16'h0200 + i), 16'(16'h5000 + i), 16'(16'h6000 + i));
      #1;
      n_checks++;
      if (stall_if_id !== 1'b1) $display("FAIL ms_stall[%0d] got %b want 1", i, stall_if_id);
      else n_pass++;
      tick();
      n_checks++;
      if ({ex_valid, ex_opcode, ex_pc, ex_data1, ex_mem_write, ex_imm} !==
          {1'b1, 4'h3, 16'h0100, 16'hAAAA, 1'b1, 16'h0042})
        $display("FAIL ms_hold[%0d] got v=%b op=%h pc=%h d1=%h mw=%b imm=%h want 1 3 0100 aaaa 1 0042",
                 i, ex_valid, ex_opcode, ex_pc, ex_data1, ex_mem_write, ex_imm);
      else n_pass++;
    end
    mem_stall = 1'b0;
    tick();
    n_checks++;
    if ({ex_valid, ex_opcode, ex_pc, ex_data1} !== {1'b1, 4'h6, 16'h0202, 16'h5002})
      $display("FAIL ms_release got v=%b op=%h pc=%h d1=%h want 1 6 0202 5002",
               ex_valid, ex_opcode, ex_pc, ex_data1);
    else n_pass++;
  endtask

  task automatic test_flush();
    set_id(1'b1, 4'h8, 4'h1, 1'b1, 4'h0, 1'b0, 4'h5, 1'b1, 1'b1, 1'b0,
           16'h0000, 16'h0300, 16'h0000, 16'h0000);
    tick();
    set_id(1'b1, 4'h2, 4'h5, 1'b1, 4'h0, 1'b0, 4'h6, 1'b1, 1'b0, 1'b0,
           16'h0000, 16'h0302, 16'h0000, 16'h0000);
    flush = 1'b1;
    #1;
    n_checks++;
    if (stall_if_id !== 1'b0) $display("FAIL fl_lu_stall got %b want 0", stall_if_id);
    else n_pass++;
    tick();
    n_checks++;
    if ({ex_valid, ex_pc, bubble_count} !== {1'b0, 16'h0000, 16'h0002})
      $display("FAIL fl_lu got v=%b pc=%h cnt=%h want 0 0000 0002",
               ex_valid, ex_pc, bubble_count);
    else n_pass++;
    flush = 1'b0;
    set_id(1'b1, 4'h1, 4'h1, 1'b1, 4'h2, 1'b1, 4'h3, 1'b1, 1'b0, 1'b0,
           16'h0000, 16'h0310, 16'h0000, 16'h0000);
    tick();
    mem_stall = 1'b1; flush = 1'b1;
    set_id(1'b1, 4'h1, 4'h1, 1'b1, 4'h2, 1'b1, 4'h3, 1'b1, 1'b0, 1'b0,
           16'h0000, 16'h0312, 16'h0000, 16'h0000);
    tick();
    n_checks++;
    if ({ex_valid, ex_pc} !== {1'b1, 16'h0310})
      $display("FAIL fl_ms_hold got v=%b pc=%h want 1 0310", ex_valid, ex_pc);
    else n_pass++;
    mem_stall = 1'b0;
    #1;
    n_checks++;
    if (stall_if_id !== 1'b0) $display("FAIL fl_ms_stall got %b want 0", stall_if_id);
    else n_pass++;
    tick();
    n_checks++;
    if ({ex_valid, ex_pc} !== {1'b0, 16'h0000})
      $display("FAIL fl_after_ms got v=%b pc=%h want 0 0000", ex_valid, ex_pc);
    else n_pass++;
    flush = 1'b0;
  endtask

  task automatic test_saturation();
    set_id(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0,
           16'h0000, 16'h0000, 16'h0000, 16'h0000);
    tick();
    mem_stall = 1'b1;
    force dut.r_bubble_count = 16'hFFFE;
    #1;
    release dut.r_bubble_count;
    mem_stall = 1'b0;
    // a load to R5 that itself reads R5 re-triggers the hazard every other cycle
    set_id(1'b1, 4'h8, 4'h5, 1'b1, 4'h0, 1'b0, 4'h5, 1'b1, 1'b1, 1'b0,
           16'h0000, 16'h0400, 16'h0000, 16'h0000);
    tick();
    tick();
    n_checks++;
    if ({ex_valid, bubble_count} !== {1'b0, 16'hFFFF})
      $display("FAIL sat_reach got v=%b cnt=%h want 0 ffff", ex_valid, bubble_count);
    else n_pass++;
    tick();
    tick();
    n_checks++;
    if ({ex_valid, bubble_count} !== {1'b0, 16'hFFFF})
      $display("FAIL sat_hold got v=%b cnt=%h want 0 ffff", ex_valid, bubble_count);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_false_hazard();
    test_mem_stall();
    test_flush();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
